// File: rtl/types_pkg.sv
// Shared types for the program loader: machine word, loader FSM states, PC stride.
package types_pkg;

    typedef logic [15:0] uword;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StCheck,
        StDone,
        StErr
    } loader_state_e;

    localparam uword PcStride = 16'd2;

endpackage

// File: rtl/adder.sv
// Plain 16-bit wrapping adder, shared with the PC increment path.
module adder
    import types_pkg::*;
(
    input  uword a,
    input  uword b,
    output uword sum
);

    assign sum = a + b;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: length header, big-endian words, XOR checksum trailer.
// Writes each word to program memory one cycle after its low byte arrives.
module prog_loader
    import types_pkg::*;
#(
    parameter uword        BASE_ADDR = 16'h0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       mem_wr_en,
    output uword       mem_wr_addr,
    output uword       mem_wr_data,
    output logic       load_halt,
    output logic       done,
    output logic       error
);

    loader_state_e state_q, state_d;
    uword          len_q, len_d;
    uword          cnt_q, cnt_d;
    uword          addr_q, addr_d;
    uword          wr_addr_q, wr_addr_d;
    uword          wr_data_q, wr_data_d;
    logic [7:0]    hi_q, hi_d;
    logic [7:0]    csum_q, csum_d;
    logic          wr_en_q, wr_en_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    uword addr_next;
    uword cnt_inc;
    uword n_words;
    logic xfer;

    adder u_addr_inc (
        .a   (addr_q),
        .b   (PcStride),
        .sum (addr_next)
    );

    assign cnt_inc = cnt_q + 16'd1;
    assign n_words = {len_q[15:8], byte_data};
    assign xfer    = byte_valid && byte_ready;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        hi_d      = hi_q;
        csum_d    = csum_q;
        wr_en_d   = 1'b0;
        done_d    = done_q;
        error_d   = error_q;

        byte_ready = state_q inside {StLenHi, StLenLo, StDataHi, StDataLo, StCheck};
        load_halt  = !(state_q inside {StIdle, StDone, StErr});

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLenHi;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    csum_d  = 8'h00;
                    cnt_d   = 16'd0;
                    addr_d  = BASE_ADDR;
                end
            end
            StLenHi: begin
                if (xfer) begin
                    len_d[15:8] = byte_data;
                    state_d     = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    len_d = n_words;
                    if (n_words == 16'd0) begin
                        state_d = StCheck;
                    end else if ({16'd0, n_words} > MAX_WORDS) begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end else begin
                        state_d = StDataHi;
                    end
                end
            end
            StDataHi: begin
                if (xfer) begin
                    hi_d    = byte_data;
                    csum_d  = csum_q ^ byte_data;
                    state_d = StDataLo;
                end
            end
            StDataLo: begin
                if (xfer) begin
                    csum_d    = csum_q ^ byte_data;
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = {hi_q, byte_data};
                    addr_d    = addr_next;
                    cnt_d     = cnt_inc;
                    state_d   = (cnt_inc == len_q) ? StCheck : StDataHi;
                end
            end
            StCheck: begin
                if (xfer) begin
                    if (byte_data == csum_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            len_q     <= 16'd0;
            cnt_q     <= 16'd0;
            addr_q    <= 16'd0;
            wr_addr_q <= 16'd0;
            wr_data_q <= 16'd0;
            hi_q      <= 8'h00;
            csum_q    <= 8'h00;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            hi_q      <= hi_d;
            csum_q    <= csum_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // A pending strobe is killed by rst in the same cycle so an aborted load never writes.
    assign mem_wr_en   = wr_en_q & ~rst;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad checksum, empty and oversize loads, gaps, reset abort.
module tb_prog_loader;
    import types_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_ready;
    logic       mem_wr_en;
    uword       mem_wr_addr;
    uword       mem_wr_data;
    logic       load_halt;
    logic       done;
    logic       error;

    int n_checks = 0;
    int n_pass   = 0;

    uword wa[$];
    uword wd[$];

    prog_loader #(
        .BASE_ADDR (16'h0000),
        .MAX_WORDS (256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .load_halt   (load_halt),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            wa.push_back(mem_wr_addr);
            wd.push_back(mem_wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents one byte, waits (bounded) for byte_ready, returns 1 time unit after the transfer.
    task automatic send_byte(input logic [7:0] b, input logic st);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        start      = st;
        while (!byte_ready && n < 20) begin
            tick();
            start = 1'b0;
            n++;
        end
        if (n == 20) check("ready_timeout", 32'(byte_ready), 32'd1);
        tick();
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic send_list(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i], 1'b0);
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    initial begin
        logic [7:0] s5[$];
        int g;

        // Reset values
        tick();
        tick();
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_addr", 32'(mem_wr_addr), 32'd0);
        check("rst_data", 32'(mem_wr_data), 32'd0);
        check("rst_halt", 32'(load_halt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        rst = 1'b0;
        tick();

        // Good two-word load
        clear_log();
        do_start();
        check("t1_halt_after_start", 32'(load_halt), 32'd1);
        check("t1_ready_lenhi", 32'(byte_ready), 32'd1);
        send_list('{8'h00, 8'h02, 8'h12});
        check("t1_no_early_wr", 32'(mem_wr_en), 32'd0);
        send_byte(8'h34, 1'b0);
        check("t1_wr_latency", 32'(mem_wr_en), 32'd1);
        check("t1_wr_addr0", 32'(mem_wr_addr), 32'h0000);
        check("t1_wr_data0", 32'(mem_wr_data), 32'h1234);
        send_byte(8'hAB, 1'b0);
        check("t1_wr_one_cycle", 32'(mem_wr_en), 32'd0);
        check("t1_halt_mid", 32'(load_halt), 32'd1);
        send_list('{8'hCD, 8'h40});
        check("t1_done", 32'(done), 32'd1);
        check("t1_error", 32'(error), 32'd0);
        check("t1_halt_done", 32'(load_halt), 32'd0);
        tick();
        check("t1_idle_ready", 32'(byte_ready), 32'd0);
        check("t1_done_sticky", 32'(done), 32'd1);
        check("t1_nwr", 32'(wa.size()), 32'd2);
        check("t1_addr1", 32'(wa[1]), 32'h0002);
        check("t1_data1", 32'(wd[1]), 32'hABCD);

        // Bad checksum: writes stay, error raised
        clear_log();
        do_start();
        check("t2_done_cleared", 32'(done), 32'd0);
        send_list('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41});
        check("t2_error", 32'(error), 32'd1);
        check("t2_done", 32'(done), 32'd0);
        tick();
        check("t2_idle_halt", 32'(load_halt), 32'd0);
        check("t2_idle_ready", 32'(byte_ready), 32'd0);
        check("t2_nwr", 32'(wa.size()), 32'd2);
        check("t2_data0", 32'(wd[0]), 32'h1234);

        // Empty load
        clear_log();
        do_start();
        check("t3_error_cleared", 32'(error), 32'd0);
        send_list('{8'h00, 8'h00, 8'h00});
        check("t3_done", 32'(done), 32'd1);
        tick();
        check("t3_nwr", 32'(wa.size()), 32'd0);

        // Oversize length
        clear_log();
        do_start();
        send_list('{8'h01, 8'h01});
        check("t4_error", 32'(error), 32'd1);
        check("t4_ready", 32'(byte_ready), 32'd0);
        tick();
        check("t4_halt", 32'(load_halt), 32'd0);
        check("t4_nwr", 32'(wa.size()), 32'd0);

        // Valid bytes in IDLE are ignored
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        tick();
        tick();
        check("t5_idle_valid_ready", 32'(byte_ready), 32'd0);
        check("t5_idle_valid_halt", 32'(load_halt), 32'd0);
        byte_valid = 1'b0;

        // Four words with random gaps and stray start pulses
        clear_log();
        s5 = '{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
        do_start();
        foreach (s5[i]) begin
            g = (i == 5) ? 1 : $urandom_range(0, 2);
            repeat (g) begin
                start = (i == 5);
                tick();
                start = 1'b0;
            end
            send_byte(s5[i], i == 7);
        end
        check("t5_done", 32'(done), 32'd1);
        check("t5_error", 32'(error), 32'd0);
        tick();
        check("t5_nwr", 32'(wa.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_addr%0d", i), 32'(wa[i]), 32'(2 * i));
            check($sformatf("t5_data%0d", i), 32'(wd[i]), 32'((2 * i + 1) * 256 + 2 * i + 2));
        end

        // Reset right after a low-byte transfer suppresses the write
        clear_log();
        do_start();
        send_list('{8'h00, 8'h01, 8'h12, 8'h34});
        rst = 1'b1;
        #1;
        check("t6_no_strobe", 32'(mem_wr_en), 32'd0);
        tick();
        rst = 1'b0;
        check("t6_ready", 32'(byte_ready), 32'd0);
        check("t6_halt", 32'(load_halt), 32'd0);
        check("t6_addr", 32'(mem_wr_addr), 32'd0);
        check("t6_data", 32'(mem_wr_data), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_error", 32'(error), 32'd0);
        check("t6_nwr", 32'(wa.size()), 32'd0);
        clear_log();
        do_start();
        send_list('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40});
        check("t6_reload_done", 32'(done), 32'd1);
        tick();
        check("t6_reload_nwr", 32'(wa.size()), 32'd2);
        check("t6_reload_addr1", 32'(wa[1]), 32'h0002);
        check("t6_reload_data1", 32'(wd[1]), 32'hABCD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
